// File: rtl/coproc_arbiter_if.sv
// Requester and control-unit handshake bundle for coproc_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface coproc_arbiter_if;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [1:0] size0, size1;
  logic       gnt0, gnt1;
  logic       done0, done1;
  logic       cu_start;
  logic [2:0] cu_opcode;
  logic [1:0] cu_msize;
  logic       cu_ready;
  logic       cu_overflow;
  logic       ovf_o;
  logic       timeout_o;
  logic       busy;

  modport slave (
    input  req0, req1, op0, op1, size0, size1, cu_ready, cu_overflow,
    output gnt0, gnt1, done0, done1, cu_start, cu_opcode, cu_msize,
           ovf_o, timeout_o, busy
  );

  modport master (
    output req0, req1, op0, op1, size0, size1, cu_ready, cu_overflow,
    input  gnt0, gnt1, done0, done1, cu_start, cu_opcode, cu_msize,
           ovf_o, timeout_o, busy
  );
endinterface

// File: rtl/coproc_arbiter.sv
// Two-port round-robin arbiter in front of a matrix coprocessor control unit.
// Define ARB_TIMEOUT_EN to enable the WAIT-state watchdog (limit TIMEOUT_CYCLES).
module coproc_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic            clk,
  input  logic            rst,
  coproc_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("coproc_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_e;

  state_e     state_q;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic       cu_start_q;
  logic [2:0] opcode_q;
  logic [1:0] msize_q;
  logic       ovf_q;
  logic       busy_q;
  logic       last1_q;   // requester 1 was served last
  logic       pick1_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pick1_d = 1'b0;
    if (bus.req0 && bus.req1) pick1_d = ~last1_q;
    else                      pick1_d = bus.req1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        timeout_q;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      cu_start_q <= 1'b0;
      opcode_q   <= 3'b000;
      msize_q    <= 2'b00;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      last1_q    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= 16'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt_q      <= pick1_d ? 2'b10 : 2'b01;
            opcode_q   <= pick1_d ? bus.op1 : bus.op0;
            msize_q    <= pick1_d ? bus.size1 : bus.size0;
            cu_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          cu_start_q <= 1'b0;
          state_q    <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
          cnt_q      <= 16'd0;
`endif
        end
        S_WAIT: begin
          if (bus.cu_ready) begin
            ovf_q     <= bus.cu_overflow;
            done_q    <= gnt_q;
            state_q   <= S_DONE;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            // Watchdog abort: report as a completion with no valid overflow.
            timeout_q <= 1'b1;
            ovf_q     <= 1'b0;
            done_q    <= gnt_q;
            state_q   <= S_DONE;
          end else begin
            cnt_q     <= cnt_q + 16'd1;
`endif
          end
        end
        S_DONE: begin
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
          last1_q <= gnt_q[1];
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt_q[0];
  assign bus.gnt1      = gnt_q[1];
  assign bus.done0     = done_q[0];
  assign bus.done1     = done_q[1];
  assign bus.cu_start  = cu_start_q;
  assign bus.cu_opcode = opcode_q;
  assign bus.cu_msize  = msize_q;
  assign bus.ovf_o     = ovf_q;
  assign bus.busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_coproc_arbiter.sv
// Randomised + directed bench for coproc_arbiter against a cycle-count model
// of the arbitration/handshake rules; honours ARB_TIMEOUT_EN when defined.
module tb_coproc_arbiter;
  localparam int unsigned TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  coproc_arbiter_if bus();

  coproc_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: owner of the current operation, cycles since grant (0 = start
  // cycle, k = k-th wait cycle), and whether the completion cycle is showing.
  int       m_owner = -1;
  int       m_age   = 0;
  bit       m_fin   = 1'b0;
  bit       m_last1 = 1'b1;
  bit [2:0] m_op    = 3'd0;
  bit [1:0] m_sz    = 2'd0;
  bit       m_ovf   = 1'b0;
  bit       m_tmo   = 1'b0;

  always @(posedge clk or negedge rst) begin
    int w;
    if (!rst) begin
      m_owner = -1; m_age = 0; m_fin = 1'b0; m_last1 = 1'b1;
      m_op = 3'd0; m_sz = 2'd0; m_ovf = 1'b0; m_tmo = 1'b0;
    end else if (m_owner < 0) begin
      if (bus.req0 || bus.req1) begin
        if (bus.req0 && bus.req1) w = m_last1 ? 0 : 1;
        else                      w = bus.req0 ? 0 : 1;
        m_owner = w; m_age = 0; m_fin = 1'b0;
        m_op = (w == 1) ? bus.op1 : bus.op0;
        m_sz = (w == 1) ? bus.size1 : bus.size0;
      end
    end else if (m_fin) begin
      m_last1 = (m_owner == 1);
      m_owner = -1; m_fin = 1'b0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (bus.cu_ready) begin
      m_fin = 1'b1; m_ovf = bus.cu_overflow; m_tmo = 1'b0;
    end else if (TO_EN && m_age >= int'(TO)) begin
      m_fin = 1'b1; m_tmo = 1'b1; m_ovf = 1'b0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("gnt0",      32'(bus.gnt0),      32'(m_owner == 0));
      check("gnt1",      32'(bus.gnt1),      32'(m_owner == 1));
      check("done0",     32'(bus.done0),     32'(m_owner == 0 && m_fin));
      check("done1",     32'(bus.done1),     32'(m_owner == 1 && m_fin));
      check("cu_start",  32'(bus.cu_start),  32'(m_owner >= 0 && m_age == 0));
      check("cu_opcode", 32'(bus.cu_opcode), 32'(m_op));
      check("cu_msize",  32'(bus.cu_msize),  32'(m_sz));
      check("ovf_o",     32'(bus.ovf_o),     32'(m_ovf));
      check("timeout_o", 32'(bus.timeout_o), 32'(m_tmo));
      check("busy",      32'(bus.busy),      32'(m_owner >= 0));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      tick();
    end
    check("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int       starts, dones, nwait;
    bit       seen;
    int       order[$];

    bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
    bus.size0 = 0; bus.size1 = 0; bus.cu_ready = 0; bus.cu_overflow = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_gnt",     32'({bus.gnt1, bus.gnt0}), 32'd0);
    check("rst_done",    32'({bus.done1, bus.done0}), 32'd0);
    check("rst_start",   32'(bus.cu_start), 32'd0);
    check("rst_op_sz",   32'({bus.cu_opcode, bus.cu_msize}), 32'd0);
    check("rst_flags",   32'({bus.ovf_o, bus.timeout_o, bus.busy}), 32'd0);
    tick(); #1 rst = 1'b1;

    // Single host operation: size 5x5 add, ready after 5 wait cycles with overflow.
    bus.req0 = 1; bus.op0 = 3'b000; bus.size0 = 2'b11;
    tick();
    check("t1_gnt0",   32'(bus.gnt0), 32'd1);
    check("t1_start",  32'(bus.cu_start), 32'd1);
    check("t1_opc",    32'(bus.cu_opcode), 32'd0);
    check("t1_msize",  32'(bus.cu_msize), 32'd3);
    bus.op0 = 3'b101; bus.size0 = 2'b01;
    repeat (6) tick();
    check("t1_hold_opc", 32'(bus.cu_opcode), 32'd0);
    check("t1_hold_sz",  32'(bus.cu_msize), 32'd3);
    check("t1_no_done",  32'(bus.done0), 32'd0);
    bus.cu_ready = 1; bus.cu_overflow = 1;
    tick();
    check("t1_done0", 32'(bus.done0), 32'd1);
    check("t1_ovf",   32'(bus.ovf_o), 32'd1);
    bus.cu_ready = 0; bus.cu_overflow = 0; bus.req0 = 0;
    tick();
    check("t1_done_pulse", 32'({bus.done0, bus.gnt0, bus.busy}), 32'd0);
    check("t1_ovf_hold",   32'(bus.ovf_o), 32'd1);

    // Both requesters held from reset: grants alternate 0,1,0.
    #1 rst = 1'b0;
    tick(); #1 rst = 1'b1;
    bus.req0 = 1; bus.req1 = 1; bus.cu_ready = 1;
    for (int i = 0; i < 40 && order.size() < 3; i++) begin
      tick();
      check("rr_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      if (bus.cu_start) order.push_back(int'(bus.gnt1));
    end
    check("rr_count", 32'(order.size()), 32'd3);
    check("rr_first",  32'(order.size() > 0 ? order[0] : 9), 32'd0);
    check("rr_second", 32'(order.size() > 1 ? order[1] : 9), 32'd1);
    check("rr_third",  32'(order.size() > 2 ? order[2] : 9), 32'd0);
    bus.req0 = 0; bus.req1 = 0;
    wait_idle();
    bus.cu_ready = 0;

    // Debug port drops its request one cycle after the grant.
    bus.req1 = 1; bus.op1 = 3'b110; bus.size1 = 2'b10;
    tick();
    check("t3_gnt1", 32'(bus.gnt1), 32'd1);
    check("t3_opc",  32'(bus.cu_opcode), 32'd6);
    starts = int'(bus.cu_start); dones = 0;
    tick();
    bus.req1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) bus.cu_ready = 1;
      tick();
      starts += int'(bus.cu_start);
      dones  += int'(bus.done1);
    end
    check("t3_starts", 32'(starts), 32'd1);
    check("t3_done1",  32'(dones), 32'd1);
    bus.cu_ready = 0;

    // Host completes (last served = 0), then reset hits requester 1 mid-wait.
    bus.req0 = 1; bus.cu_ready = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = bus.done0; end
    check("t4_host_done", 32'(seen), 32'd1);
    bus.req0 = 0;
    wait_idle();
    bus.cu_ready = 0; bus.req1 = 1;
    repeat (3) tick();
    check("t4_gnt1_wait", 32'(bus.gnt1), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t4_rst_gnt",   32'({bus.gnt1, bus.gnt0}), 32'd0);
    check("t4_rst_busy",  32'(bus.busy), 32'd0);
    check("t4_rst_start", 32'(bus.cu_start), 32'd0);
    check("t4_rst_done",  32'({bus.done1, bus.done0}), 32'd0);
    bus.req0 = 1;
    tick(); #1 rst = 1'b1;
    tick();
    check("t4_prio_gnt0", 32'(bus.gnt0), 32'd1);
    check("t4_prio_gnt1", 32'(bus.gnt1), 32'd0);
    bus.req0 = 0; bus.req1 = 0; bus.cu_ready = 1; bus.cu_overflow = 1;
    wait_idle();
    bus.cu_ready = 0; bus.cu_overflow = 0;

    // Control unit never answers.
    bus.req0 = 1;
    tick();
    bus.req0 = 0;
    nwait = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.done0) seen = 1; else nwait++;
    end
    if (TO_EN) begin
      check("t5_to_done",  32'(seen), 32'd1);
      check("t5_to_waits", 32'(nwait), 32'(TO));
      check("t5_to_flag",  32'(bus.timeout_o), 32'd1);
      check("t5_to_ovf",   32'(bus.ovf_o), 32'd0);
    end else begin
      check("t5_no_done",  32'(seen), 32'd0);
      check("t5_busy",     32'(bus.busy), 32'd1);
      check("t5_gnt0",     32'(bus.gnt0), 32'd1);
      check("t5_no_to",    32'(bus.timeout_o), 32'd0);
    end
    bus.cu_ready = 1;
    wait_idle();
    bus.cu_ready = 0;

    // Random traffic, with an occasional asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      tick();
      bus.req0 = bus.req0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      bus.req1 = bus.req1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      bus.op0 = 3'($urandom_range(0, 6));
      bus.op1 = 3'($urandom_range(0, 6));
      bus.size0 = 2'($urandom);
      bus.size1 = 2'($urandom);
      bus.cu_ready = ($urandom_range(0, 3) == 0);
      bus.cu_overflow = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        tick(); #1 rst = 1'b1;
      end
    end

    bus.req0 = 0; bus.req1 = 0; bus.cu_ready = 1;
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
